alu_share_arb: RTL and testbench
================================

// Module: alu_share_arb
// PURPOSE
//   Shares one combinational yAlu between NREQ requesters. Round-robin arbiter
//   plus 3-state sequencer: accept an operand set, drive the ALU for one cycle,
//   register z/ex, return a tagged response over a valid/ready handshake.
//   Sits between datapath clients and a single yAlu instance outside this block.
// PARAMETERS
//   NREQ   4   number of requesters (2..8)
//   WIDTH  32  operand/result width; must match the attached ALU
//   IDW    2   width of rsp_id, clog2(NREQ)
// PORTS
//   clk        in   1           single clock, rising edge
//   rst_n      in   1           synchronous reset, active low
//   req_valid  in   NREQ        per-requester request valid
//   req_ready  out  NREQ        per-requester accept, one-hot or zero
//   req_a      in   NREQ*WIDTH  operand a; slice i = [i*WIDTH +: WIDTH]
//   req_b      in   NREQ*WIDTH  operand b, same packing
//   req_op     in   NREQ*3      ALU opcode; slice i = [i*3 +: 3]
//   alu_a      out  WIDTH       to yAlu a
//   alu_b      out  WIDTH       to yAlu b
//   alu_op     out  3           to yAlu op
//   alu_z      in   WIDTH       from yAlu z
//   alu_ex     in   1           from yAlu ex
//   rsp_valid  out  1           response valid
//   rsp_ready  in   1           response consumer ready
//   rsp_z      out  WIDTH       registered result
//   rsp_ex     out  1           registered ALU ex flag
//   rsp_id     out  IDW         index of the requester served
//   rsp_err    out  1           illegal-opcode flag (see CONFIGURATION)
// BEHAVIOUR
//   Reset (rst_n low at a clk edge): state=IDLE, ptr=NREQ-1, rsp_valid=0,
//   rsp_z=0, rsp_ex=0, rsp_id=0, rsp_err=0, operand regs=0, so alu_a/b/op=0.
//   req_ready=0 in every state except IDLE. Reset mid-operation drops the op.
//   No response is produced for it.
//   IDLE: g = first i with req_valid[i] set, scanning ptr+1, ptr+2, ... mod NREQ.
//     If one exists: req_ready[g]=1 (combinational, same cycle). Latch a/b/op/id
//     of g, ptr<=g, go to EXEC. If none: stay, req_ready=0.
//   EXEC: alu_a/b/op driven from the latched regs for the whole cycle. At the
//     edge, rsp_z<=alu_z, rsp_ex<=alu_ex, rsp_id<=id, rsp_valid<=1. Go to RESP.
//   RESP: outputs held stable while rsp_valid=1 and rsp_ready=0.
//     When rsp_ready=1: rsp_valid<=0, go to IDLE. rsp_z/ex/id keep their values.
//   Latency: accept edge -> rsp_valid high 2 edges later. Min 3 cycles per op,
//     no overlap. A requester whose req_valid drops before grant is skipped.
//   Handshake: requester holds req_valid and operands until it sees req_ready.
//     Deassert at the next edge.
//   Fairness: after requester g is served, g has lowest priority. Any continuously
//     requesting client is granted within NREQ grants.
//   alu_a/b/op always come from the latched regs, so they are stable outside EXEC.
//   rsp_ready while rsp_valid=0 is ignored.
// CONFIGURATION
//   ALU_OPCHECK_EN defined: legal ops are 000 (&), 001 (|), 010 (+), 110 (-).
//     Illegal op: EXEC is still taken, but capture sets rsp_err=1, rsp_z=0,
//     rsp_ex=0. Legal op: rsp_err=0.
//   Not defined: rsp_err tied 0. Every opcode is passed through and the ALU
//     output is captured as is.
// TESTING
//   1 reset: rst_n=0 for 2 cycles, req_valid=4'b1111 -> req_ready=0, rsp_valid=0,
//     rsp_z=0. First grant after release is req0.
//   2 single op: req1 a=32'h0000_00F0 b=32'h0000_0F0F op=010 -> req_ready[1] at
//     cycle 0. rsp_valid at cycle 2: rsp_z=32'h0000_0FFF, rsp_id=1.
//   3 round-robin: req_valid=4'b1111 held, rsp_ready=1 -> grant order
//     0,1,2,3,0. One grant every 3 cycles.
//   4 backpressure: rsp_ready=0 for 5 cycles on a 6-2 (op=110) result ->
//     rsp_z=4, rsp_valid held, no req_ready asserted. Release -> IDLE next cycle.
//   5 ops: a=32'hFFFF_0000 b=32'h0F0F_0F0F with op 000/001/110 ->
//     z=0F0F_0000 / FFFF_0F0F / F0EF_F0F1.
//   6 ALU_OPCHECK_EN: op=011 -> rsp_err=1, rsp_z=0. Without the macro,
//     rsp_err=0 and rsp_z equals alu_z.
//   7 reset in EXEC: rst_n low at the EXEC edge -> no response, ptr=NREQ-1.

Source files
------------

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one external combinational yAlu between NREQ requesters.
// Round-robin grant in IDLE, one ALU cycle in EXEC, and a registered, tagged
// response in RESP that is held until the consumer takes it.
// Optional build macro ALU_OPCHECK_EN: flags opcodes outside {000,001,010,110}
// through rsp_err and forces a zero result for them.
module alu_share_arb #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*3-1:0]     req_op,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [2:0]            alu_op,
  input  logic [WIDTH-1:0]      alu_z,
  input  logic                  alu_ex,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_z,
  output logic                  rsp_ex,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_err
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

  state_t           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [IDW-1:0]   id_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_z_q;
  logic             rsp_ex_q;
  logic [IDW-1:0]   rsp_id_q;

  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [2:0]       sel_op;

`ifdef ALU_OPCHECK_EN
  logic rsp_err_q;

  function automatic logic op_legal(input logic [2:0] op);
    return op inside {3'b000, 3'b001, 3'b010, 3'b110};
  endfunction
`endif

  // Round-robin search starting just after the last served requester
  always_comb begin
    int unsigned     idx;
    logic [NREQ-1:0] rot;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    rot       = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      rot = req_valid >> idx;
      if (!gnt_found && rot[0]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(idx);
      end
    end
  end

  // Operand mux for the candidate grant
  always_comb begin
    sel_a  = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
    sel_b  = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
    sel_op = req_op[int'(gnt_idx)*3 +: 3];
  end

  // Grant is only offered in IDLE and never while reset is asserted
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == StIdle) && gnt_found) begin
      req_ready = {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx;
    end
  end

  // Sequencer: accept, run the ALU for one cycle, hold the response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= IDW'(NREQ - 1);
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_z_q     <= '0;
      rsp_ex_q    <= 1'b0;
      rsp_id_q    <= '0;
`ifdef ALU_OPCHECK_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt_found) begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            op_q    <= sel_op;
            id_q    <= gnt_idx;
            ptr_q   <= gnt_idx;
            state_q <= StExec;
          end
        end
        StExec: begin
          rsp_valid_q <= 1'b1;
          rsp_id_q    <= id_q;
`ifdef ALU_OPCHECK_EN
          if (op_legal(op_q)) begin
            rsp_z_q   <= alu_z;
            rsp_ex_q  <= alu_ex;
            rsp_err_q <= 1'b0;
          end else begin
            rsp_z_q   <= '0;
            rsp_ex_q  <= 1'b0;
            rsp_err_q <= 1'b1;
          end
`else
          rsp_z_q     <= alu_z;
          rsp_ex_q    <= alu_ex;
`endif
          state_q     <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // ALU is always fed from the latched operands so it is quiet outside EXEC
  always_comb begin
    alu_a     = a_q;
    alu_b     = b_q;
    alu_op    = op_q;
    rsp_valid = rsp_valid_q;
    rsp_z     = rsp_z_q;
    rsp_ex    = rsp_ex_q;
    rsp_id    = rsp_id_q;
`ifdef ALU_OPCHECK_EN
    rsp_err   = rsp_err_q;
`else
    rsp_err   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: an external yAlu stand-in, a transaction-level model
// checked every negedge, and directed scenarios with literal expectations.
module tb_alu_share_arb;
  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*3-1:0]     req_op;
  logic [WIDTH-1:0]      alu_a, alu_b, alu_z;
  logic [2:0]            alu_op;
  logic                  alu_ex;
  logic                  rsp_valid, rsp_ready, rsp_ex, rsp_err;
  logic [WIDTH-1:0]      rsp_z;
  logic [IDW-1:0]        rsp_id;

  alu_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_z(alu_z), .alu_ex(alu_ex),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_z(rsp_z), .rsp_ex(rsp_ex), .rsp_id(rsp_id), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // yAlu stand-in; ex flags a zero result
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_z  = alu_f(alu_a, alu_b, alu_op);
  assign alu_ex = (alu_z == '0);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // ---------------- transaction-level model ----------------
  bit          m_on = 1'b0;
  int          m_stage;          // 0 waiting for grant, 1 op in ALU, 2 response out
  int          m_ptr;
  logic [31:0] m_a, m_b, m_z;
  logic [2:0]  m_op;
  int          m_lid, m_rid;
  logic        m_rv, m_ex, m_err;
  int          g_m, g_c;
  int          cyc = 0;

  function automatic int m_pick();
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_on = 1'b1; m_stage = 0; m_ptr = NREQ - 1;
      m_a = '0; m_b = '0; m_op = '0; m_lid = 0;
      m_rv = 1'b0; m_z = '0; m_ex = 1'b0; m_rid = 0; m_err = 1'b0;
    end else if (m_on) begin
      case (m_stage)
        0: begin
          g_m = m_pick();
          if (g_m >= 0) begin
            m_ptr = g_m; m_lid = g_m;
            m_a = req_a[g_m*WIDTH +: WIDTH];
            m_b = req_b[g_m*WIDTH +: WIDTH];
            m_op = req_op[g_m*3 +: 3];
            m_stage = 1;
          end
        end
        1: begin
          m_z = alu_f(m_a, m_b, m_op);
          m_ex = (m_z == 0);
          m_err = 1'b0;
`ifdef ALU_OPCHECK_EN
          if (!(m_op inside {3'b000, 3'b001, 3'b010, 3'b110})) begin
            m_z = '0; m_ex = 1'b0; m_err = 1'b1;
          end
`endif
          m_rid = m_lid; m_rv = 1'b1; m_stage = 2;
        end
        default: begin
          if (rsp_ready) begin
            m_rv = 1'b0; m_stage = 0;
          end
        end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [NREQ-1:0] gnt_neg = '0;
  logic [NREQ-1:0] exp_rdy;
  int grants[$];
  int gcyc[$];

  always @(negedge clk) begin
    gnt_neg = req_ready;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        grants.push_back(i);
        gcyc.push_back(cyc);
      end
    end
    if (m_on) begin
      g_c = m_pick();
      exp_rdy = '0;
      if (rst_n && m_stage == 0 && g_c >= 0) exp_rdy[g_c] = 1'b1;
      chk("m_req_ready", req_ready, exp_rdy);
      chk("m_rsp_valid", rsp_valid, m_rv);
      chk("m_rsp_z", rsp_z, m_z);
      chk("m_rsp_ex", rsp_ex, m_ex);
      chk("m_rsp_id", rsp_id, m_rid);
      chk("m_rsp_err", rsp_err, m_err);
      chk("m_alu_a", alu_a, m_a);
      chk("m_alu_b", alu_b, m_b);
      chk("m_alu_op", alu_op, m_op);
    end
  end

  // ---------------- stimulus helpers ----------------
  bit hold_all = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~gnt_neg;
    if (hold_all) req_valid = '1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_op[i*3 +: 3] = op;
    req_valid[i] = 1'b1;
  endtask

  // Waits for grant eg, then the response; checks latency, result and tag
  task automatic wait_rsp(input string nm, input logic [NREQ-1:0] eg,
                          input logic [31:0] ez, input int eid);
    int n;
    bit done;
    n = -1;
    done = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      @(negedge clk);
      if (n < 0) begin
        if (req_ready == eg) n = 0;
      end else begin
        n++;
      end
      if (n >= 0 && rsp_valid) done = 1'b1;
      else tick();
    end
    if (!done) begin
      fail_now({nm, "_timeout"});
    end else begin
      chk({nm, "_lat"}, 64'(n), 64'd2);
      chk({nm, "_z"}, rsp_z, ez);
      chk({nm, "_id"}, rsp_id, eid);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int          exp_order[5] = '{0, 1, 2, 3, 0};
  logic [2:0]  ops5[3]      = '{3'b000, 3'b001, 3'b110};
  logic [31:0] z5[3]        = '{32'h0F0F_0000, 32'hFFFF_0F0F, 32'hF0EF_F0F1};
  string       n5[3]        = '{"op_and", "op_or", "op_sub"};

  initial begin
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b1;

    // Reset with every requester asking, then round-robin from req0
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i + 1), 32'd10, 3'b010);
    hold_all = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_z", rsp_z, 0);
    tick();
    grants.delete();
    gcyc.delete();
    rst_n = 1'b1;
    repeat (14) tick();
    hold_all = 1'b0;
    req_valid = '0;
    if (grants.size() < 5) begin
      fail_now("rr_grant_count");
    end else begin
      for (int j = 0; j < 5; j++) chk("rr_order", 64'(grants[j]), 64'(exp_order[j]));
      for (int j = 0; j < 4; j++) chk("rr_spacing", 64'(gcyc[j+1] - gcyc[j]), 64'd3);
    end
    repeat (6) tick();

    // Single op on req1
    set_req(1, 32'h0000_00F0, 32'h0000_0F0F, 3'b010);
    wait_rsp("single", 4'b0010, 32'h0000_0FFF, 1);
    tick();

    // Backpressure on 6-2, with req0 waiting behind it
    rsp_ready = 1'b0;
    set_req(2, 32'd6, 32'd2, 3'b110);
    wait_rsp("bp", 4'b0100, 32'd4, 2);
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) set_req(0, 32'h11, 32'h22, 3'b001);
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_z", rsp_z, 32'd4);
      chk("bp_ready", req_ready, 0);
    end
    tick();
    rsp_ready = 1'b1;
    wait_rsp("bp_rel", 4'b0001, 32'h33, 0);
    tick();

    // Opcode sweep on req3
    for (int j = 0; j < 3; j++) begin
      set_req(3, 32'hFFFF_0000, 32'h0F0F_0F0F, ops5[j]);
      wait_rsp(n5[j], 4'b1000, z5[j], 3);
      tick();
    end

    // Opcode outside the checked set
    set_req(0, 32'd5, 32'd3, 3'b011);
`ifdef ALU_OPCHECK_EN
    wait_rsp("badop", 4'b0001, 32'd0, 0);
    chk("badop_err", rsp_err, 1);
`else
    wait_rsp("badop", 4'b0001, 32'd6, 0);
    chk("badop_err", rsp_err, 0);
`endif
    tick();

    // Reset landing on the EXEC edge drops the op and rewinds the pointer
    set_req(1, 32'd1, 32'd2, 3'b010);
    @(negedge clk);
    chk("rx_gnt", req_ready, 4'b0010);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rx_norsp", rsp_valid, 0);
      tick();
    end
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i), 32'(i), 3'b000);
    wait_rsp("rx_first", 4'b0001, 32'd0, 0);
    repeat (15) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
